rx_payload_alloc: RTL
=====================

RX_PAYLOAD_ALLOC -- requirements
Module: rx_payload_alloc

Interface
REQ-001 Parameter FLOWID_W, default FLOWID_W (tcp_pkg), flow ID width.
REQ-002 Parameter PTR_W, default RX_PAYLOAD_PTR_W (tcp_pkg); the per-flow buffer is 2^PTR_W bytes and pointers are PTR_W+1 bits (MSB = wrap bit).
REQ-003 Parameter LEN_W, default 16, payload length width.
REQ-004 Clocking: one clock; reset is asynchronous and active-high.
REQ-005 clk  in  1  sole clock.
REQ-006 rst  in  1  asynchronous active-high reset.
REQ-007 alloc_req_val/alloc_req_rdy  in/out  1/1  allocation request handshake.
REQ-008 alloc_req_flowid  in  FLOWID_W  flow being allocated.
REQ-009 alloc_req_len  in  LEN_W  payload bytes to allocate.
REQ-010 head_ptr_rd_req_val/rdy  out/in  1/1  head-pointer read request handshake.
REQ-011 head_ptr_rd_req_addr  out  FLOWID_W  head-pointer read address.
REQ-012 head_ptr_rd_resp_val/rdy  in/out  1/1  head-pointer read response handshake.
REQ-013 head_ptr_rd_resp_data  in  PTR_W+1  head pointer read back.
REQ-014 tail_ptr_rd_req_val/rdy, tail_ptr_rd_req_addr, tail_ptr_rd_resp_val/rdy, tail_ptr_rd_resp_data  same directions and widths as REQ-010..013  tail-pointer read.
REQ-015 tail_ptr_wr_req_val/rdy  out/in  1/1  tail-pointer write handshake.
REQ-016 tail_ptr_wr_req_addr  out  FLOWID_W  tail-pointer write address.
REQ-017 tail_ptr_wr_req_data  out  PTR_W+1  new tail pointer.
REQ-018 alloc_resp_val/alloc_resp_rdy  out/in  1/1  allocation result handshake.
REQ-019 alloc_resp_accept  out  1  allocation granted.
REQ-020 alloc_resp_flowid  out  FLOWID_W  echoed flow ID.
REQ-021 alloc_resp_ptr  out  PTR_W+1  tail pointer before allocation (payload write address).
REQ-022 alloc_resp_len  out  LEN_W  echoed length.

Function
REQ-023 States: IDLE, RD_REQ, RD_RESP, WR, RESP; exactly one request is in flight at a time.
REQ-024 IDLE: alloc_req_rdy=1 (0 while rst is high); on val&rdy, flowid and len are latched and the FSM moves to RD_REQ.
REQ-025 RD_REQ: head and tail read requests are driven with the latched flowid; each is dropped once its own handshake completes, using a separate issued flag per port; the FSM moves to RD_RESP when both reads are issued (same cycle allowed).
REQ-026 RD_RESP: both resp_rdy=1 until the respective response is captured; the FSM moves to WR in the cycle after both are captured.
REQ-027 Arithmetic: used = (tail - head) mod 2^(PTR_W+1); free = 2^PTR_W - used; the compare is done at max(LEN_W, PTR_W+1)+1 bits with no truncation.
REQ-028 accept = (len <= free); len > 2^PTR_W always rejects.
REQ-029 WR: if accept and len != 0, tail_ptr_wr_req is driven with data = (tail + len) mod 2^(PTR_W+1) and held until rdy, then the FSM moves to RESP; otherwise the FSM moves to RESP with no write.
REQ-030 RESP: alloc_resp_val=1 with all fields held stable until alloc_resp_rdy; the FSM then returns to IDLE.
REQ-031 Latency with every rdy high and a 1-cycle read response: alloc_resp_val asserts 4 cycles after the alloc_req handshake.
REQ-032 Head pointer is never written by this block; no more than one tail write occurs per request.

Reset
REQ-033 On rst assertion at any point: FSM goes to IDLE, issued/captured flags clear, all val outputs and resp_rdy outputs go to 0, and the in-flight request is discarded with no tail write.
REQ-034 Data outputs reset to 0; normal operation starts on the first clk edge after rst deasserts.

Verification (PTR_W=12, capacity 4096)
REQ-035 head=0x0000, tail=0x0000, len=100 -> tail write 0x0064; resp accept=1, ptr=0x0000, after 4 cycles.
REQ-036 head=0x0000, tail=0x1000 (full), len=1 -> no tail write; resp accept=0, ptr=0x1000.
REQ-037 head=0x1000, tail=0x1F80, len=128 -> tail write 0x0000 (wrap), accept=1; repeat with len=129 -> accept=0, no write.
REQ-038 len=0 -> accept=1, no tail write; len=5000 on empty buffer -> accept=0.
REQ-039 head read rdy delayed 3 cycles, tail read rdy immediate, alloc_resp_rdy low for 5 cycles -> each read issued exactly once, resp fields stable, alloc_req_rdy=0 throughout.
REQ-040 rst pulsed while in RD_RESP -> no tail write, all vals 0, next request processed correctly.

Source files
------------

// File: rtl/rx_payload_alloc_if.sv
`default_nettype none
// ============================================================================
// Module      : rx_payload_alloc_if
// Description : Bundles every handshake/bus signal of rx_payload_alloc:
//               the allocation request and response channels, the head and
//               tail pointer read ports and the tail pointer write port.
//               master = the allocator, slave = its environment.
// Ports       : alloc_req_*      request (flowid, len) into the allocator
//               head_ptr_rd_*    head pointer read request/response
//               tail_ptr_rd_*    tail pointer read request/response
//               tail_ptr_wr_*    tail pointer write request
//               alloc_resp_*     allocation result (accept, flowid, ptr, len)
// Revision    : 1.0 - initial release
// ============================================================================
interface rx_payload_alloc_if #(
    parameter int FLOWID_W = 8,
    parameter int PTR_W    = 12,
    parameter int LEN_W    = 16
);
    logic                alloc_req_val;
    logic                alloc_req_rdy;
    logic [FLOWID_W-1:0] alloc_req_flowid;
    logic [LEN_W-1:0]    alloc_req_len;

    logic                head_ptr_rd_req_val;
    logic                head_ptr_rd_req_rdy;
    logic [FLOWID_W-1:0] head_ptr_rd_req_addr;
    logic                head_ptr_rd_resp_val;
    logic                head_ptr_rd_resp_rdy;
    logic [PTR_W:0]      head_ptr_rd_resp_data;

    logic                tail_ptr_rd_req_val;
    logic                tail_ptr_rd_req_rdy;
    logic [FLOWID_W-1:0] tail_ptr_rd_req_addr;
    logic                tail_ptr_rd_resp_val;
    logic                tail_ptr_rd_resp_rdy;
    logic [PTR_W:0]      tail_ptr_rd_resp_data;

    logic                tail_ptr_wr_req_val;
    logic                tail_ptr_wr_req_rdy;
    logic [FLOWID_W-1:0] tail_ptr_wr_req_addr;
    logic [PTR_W:0]      tail_ptr_wr_req_data;

    logic                alloc_resp_val;
    logic                alloc_resp_rdy;
    logic                alloc_resp_accept;
    logic [FLOWID_W-1:0] alloc_resp_flowid;
    logic [PTR_W:0]      alloc_resp_ptr;
    logic [LEN_W-1:0]    alloc_resp_len;

    modport master (
        input  alloc_req_val, alloc_req_flowid, alloc_req_len,
        output alloc_req_rdy,
        output head_ptr_rd_req_val, head_ptr_rd_req_addr, head_ptr_rd_resp_rdy,
        input  head_ptr_rd_req_rdy, head_ptr_rd_resp_val, head_ptr_rd_resp_data,
        output tail_ptr_rd_req_val, tail_ptr_rd_req_addr, tail_ptr_rd_resp_rdy,
        input  tail_ptr_rd_req_rdy, tail_ptr_rd_resp_val, tail_ptr_rd_resp_data,
        output tail_ptr_wr_req_val, tail_ptr_wr_req_addr, tail_ptr_wr_req_data,
        input  tail_ptr_wr_req_rdy,
        output alloc_resp_val, alloc_resp_accept, alloc_resp_flowid,
        output alloc_resp_ptr, alloc_resp_len,
        input  alloc_resp_rdy
    );

    modport slave (
        output alloc_req_val, alloc_req_flowid, alloc_req_len,
        input  alloc_req_rdy,
        input  head_ptr_rd_req_val, head_ptr_rd_req_addr, head_ptr_rd_resp_rdy,
        output head_ptr_rd_req_rdy, head_ptr_rd_resp_val, head_ptr_rd_resp_data,
        input  tail_ptr_rd_req_val, tail_ptr_rd_req_addr, tail_ptr_rd_resp_rdy,
        output tail_ptr_rd_req_rdy, tail_ptr_rd_resp_val, tail_ptr_rd_resp_data,
        input  tail_ptr_wr_req_val, tail_ptr_wr_req_addr, tail_ptr_wr_req_data,
        output tail_ptr_wr_req_rdy,
        input  alloc_resp_val, alloc_resp_accept, alloc_resp_flowid,
        input  alloc_resp_ptr, alloc_resp_len,
        output alloc_resp_rdy
    );
endinterface
`default_nettype wire

// File: rtl/rx_payload_alloc.sv
`default_nettype none
// ============================================================================
// Module      : rx_payload_alloc
// Description : Per-flow RX payload buffer allocator. For each request it
//               reads the flow's head and tail pointers, decides whether
//               len bytes fit in the 2^PTR_W byte ring, advances the tail
//               pointer when they do, and reports the result together with
//               the pre-allocation tail (the payload write address).
//               One request is in flight at a time.
// Ports       : clk  - sole clock
//               rst  - asynchronous active-high reset
//               bus  - rx_payload_alloc_if.master (all handshake channels)
// Revision    : 1.0 - initial release
// ============================================================================
module rx_payload_alloc #(
    parameter int FLOWID_W = 8,
    parameter int PTR_W    = 12,
    parameter int LEN_W    = 16
) (
    input  wire logic            clk,
    input  wire logic            rst,
    rx_payload_alloc_if.master   bus
);
    localparam int c_PW    = PTR_W + 1;
    // Wide enough that len + used never overflows.
    localparam int c_CMP_W = ((LEN_W > c_PW) ? LEN_W : c_PW) + 1;
    localparam logic [c_CMP_W-1:0] c_CAP = c_CMP_W'(1) << PTR_W;

    localparam logic [2:0] c_IDLE    = 3'd0;
    localparam logic [2:0] c_RD_REQ  = 3'd1;
    localparam logic [2:0] c_RD_RESP = 3'd2;
    localparam logic [2:0] c_WR      = 3'd3;
    localparam logic [2:0] c_RESP    = 3'd4;

    logic [2:0]          r_state;
    logic [FLOWID_W-1:0] r_flowid;
    logic [LEN_W-1:0]    r_len;
    logic [PTR_W:0]      r_head;
    logic [PTR_W:0]      r_tail;
    logic                r_req_rdy;
    logic                r_head_rd_val;
    logic                r_tail_rd_val;
    logic                r_head_issued;
    logic                r_tail_issued;
    logic                r_head_rsp_rdy;
    logic                r_tail_rsp_rdy;
    logic                r_head_got;
    logic                r_tail_got;
    logic                r_wr_val;
    logic                r_wr_pend;
    logic [PTR_W:0]      r_wr_data;
    logic                r_resp_val;
    logic                r_accept;

    logic [PTR_W:0]      w_used;
    logic [c_CMP_W-1:0]  w_need;
    logic [c_CMP_W-1:0]  w_tail_sum;
    logic                w_accept;
    logic                w_head_hs;
    logic                w_tail_hs;
    logic                w_head_cap;
    logic                w_tail_cap;

    // Pointer difference is taken modulo 2^(PTR_W+1); the wrap bit makes a
    // full ring (used == 2^PTR_W) distinguishable from an empty one.
    assign w_used     = r_tail - r_head;
    // len <= cap - used rewritten as len + used <= cap so nothing goes negative.
    assign w_need     = c_CMP_W'(r_len) + c_CMP_W'(w_used);
    assign w_accept   = (w_need <= c_CAP);
    assign w_tail_sum = c_CMP_W'(r_tail) + c_CMP_W'(r_len);

    assign w_head_hs  = r_head_rd_val & bus.head_ptr_rd_req_rdy;
    assign w_tail_hs  = r_tail_rd_val & bus.tail_ptr_rd_req_rdy;
    assign w_head_cap = r_head_rsp_rdy & bus.head_ptr_rd_resp_val;
    assign w_tail_cap = r_tail_rsp_rdy & bus.tail_ptr_rd_resp_val;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state        <= c_IDLE;
            r_flowid       <= '0;
            r_len          <= '0;
            r_head         <= '0;
            r_tail         <= '0;
            r_req_rdy      <= 1'b0;
            r_head_rd_val  <= 1'b0;
            r_tail_rd_val  <= 1'b0;
            r_head_issued  <= 1'b0;
            r_tail_issued  <= 1'b0;
            r_head_rsp_rdy <= 1'b0;
            r_tail_rsp_rdy <= 1'b0;
            r_head_got     <= 1'b0;
            r_tail_got     <= 1'b0;
            r_wr_val       <= 1'b0;
            r_wr_pend      <= 1'b0;
            r_wr_data      <= '0;
            r_resp_val     <= 1'b0;
            r_accept       <= 1'b0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    r_req_rdy <= 1'b1;
                    if (r_req_rdy && bus.alloc_req_val) begin
                        r_req_rdy     <= 1'b0;
                        r_flowid      <= bus.alloc_req_flowid;
                        r_len         <= bus.alloc_req_len;
                        r_head_rd_val <= 1'b1;
                        r_tail_rd_val <= 1'b1;
                        r_head_issued <= 1'b0;
                        r_tail_issued <= 1'b0;
                        r_state       <= c_RD_REQ;
                    end
                end
                c_RD_REQ: begin
                    if (w_head_hs) begin
                        r_head_rd_val <= 1'b0;
                        r_head_issued <= 1'b1;
                    end
                    if (w_tail_hs) begin
                        r_tail_rd_val <= 1'b0;
                        r_tail_issued <= 1'b1;
                    end
                    if ((r_head_issued || w_head_hs) && (r_tail_issued || w_tail_hs)) begin
                        r_head_rsp_rdy <= 1'b1;
                        r_tail_rsp_rdy <= 1'b1;
                        r_head_got     <= 1'b0;
                        r_tail_got     <= 1'b0;
                        r_state        <= c_RD_RESP;
                    end
                end
                c_RD_RESP: begin
                    if (w_head_cap) begin
                        r_head         <= bus.head_ptr_rd_resp_data;
                        r_head_rsp_rdy <= 1'b0;
                        r_head_got     <= 1'b1;
                    end
                    if (w_tail_cap) begin
                        r_tail         <= bus.tail_ptr_rd_resp_data;
                        r_tail_rsp_rdy <= 1'b0;
                        r_tail_got     <= 1'b1;
                    end
                    if ((r_head_got || w_head_cap) && (r_tail_got || w_tail_cap)) begin
                        r_wr_pend <= 1'b0;
                        r_state   <= c_WR;
                    end
                end
                c_WR: begin
                    // First WR cycle decides; r_wr_pend guarantees at most
                    // one tail write per request.
                    if (!r_wr_pend) begin
                        r_accept <= w_accept;
                        if (w_accept && (r_len != '0)) begin
                            r_wr_val  <= 1'b1;
                            r_wr_data <= w_tail_sum[PTR_W:0];
                            r_wr_pend <= 1'b1;
                        end else begin
                            r_resp_val <= 1'b1;
                            r_state    <= c_RESP;
                        end
                    end else if (bus.tail_ptr_wr_req_rdy) begin
                        r_wr_val   <= 1'b0;
                        r_resp_val <= 1'b1;
                        r_state    <= c_RESP;
                    end
                end
                c_RESP: begin
                    if (bus.alloc_resp_rdy) begin
                        r_resp_val <= 1'b0;
                        r_req_rdy  <= 1'b1;
                        r_state    <= c_IDLE;
                    end
                end
                default: r_state <= c_IDLE;
            endcase
        end
    end

    assign bus.alloc_req_rdy        = r_req_rdy;
    assign bus.head_ptr_rd_req_val  = r_head_rd_val;
    assign bus.head_ptr_rd_req_addr = r_flowid;
    assign bus.head_ptr_rd_resp_rdy = r_head_rsp_rdy;
    assign bus.tail_ptr_rd_req_val  = r_tail_rd_val;
    assign bus.tail_ptr_rd_req_addr = r_flowid;
    assign bus.tail_ptr_rd_resp_rdy = r_tail_rsp_rdy;
    assign bus.tail_ptr_wr_req_val  = r_wr_val;
    assign bus.tail_ptr_wr_req_addr = r_flowid;
    assign bus.tail_ptr_wr_req_data = r_wr_data;
    assign bus.alloc_resp_val       = r_resp_val;
    assign bus.alloc_resp_accept    = r_accept;
    assign bus.alloc_resp_flowid    = r_flowid;
    assign bus.alloc_resp_ptr       = r_tail;
    assign bus.alloc_resp_len       = r_len;

endmodule
`default_nettype wire
